// File: rtl/ins_atan_arbiter_if.sv
// Bundle between the requesters, the shared INS_atan unit and the arbiter.
// master = arbiter side, slave = requesters plus the INS_atan unit.
interface ins_atan_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]    req;
    logic [NREQ*32-1:0] a_in;
    logic [NREQ*32-1:0] b_in;
    logic [NREQ-1:0]    ack;
    logic [NREQ-1:0]    done;
    logic [31:0]        result;
    logic               err;
    logic               busy;
    logic               atan_en;
    logic [31:0]        atan_a;
    logic [31:0]        atan_b;
    logic [31:0]        atan_result;
    logic               atan_finish;

    modport master (
        input  req, a_in, b_in, atan_result, atan_finish,
        output ack, done, result, err, busy, atan_en, atan_a, atan_b
    );

    modport slave (
        output req, a_in, b_in, atan_result, atan_finish,
        input  ack, done, result, err, busy, atan_en, atan_a, atan_b
    );
endinterface

// File: rtl/ins_atan_arbiter.sv
// Round-robin arbiter sharing one INS_atan unit among NREQ requesters,
// with a watchdog that aborts a conversion that never finishes.
module ins_atan_arbiter #(
    parameter int NREQ    = 3,
    parameter int TMO_W   = 8,
    parameter int TIMEOUT = 200
) (
    input  logic                clk,
    input  logic                rst,
    ins_atan_arbiter_if.master  bus,
    output logic [1:0]          dbg_state_o
);
    // Handshake: req is a level held until its ack pulse; ack[i] marks the
    // edge that latched requester i's operands, done[i] (with err) is a single
    // cycle pulse carrying result, which then holds until the next done.
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  g_q, g_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [TMO_W-1:0]  wdog_q, wdog_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       result_q, result_d;
    logic              en_q, en_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic              busy_q, busy_d;

    logic              found;
    logic [IDX_W-1:0]  win;
    logic [31:0]       a_sel;
    logic [31:0]       b_sel;

    // First pass covers last+1..NREQ-1, second pass wraps to 0..last.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && bus.req[j] && (j > int'(last_q))) begin
                found = 1'b1;
                win   = IDX_W'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!found && bus.req[j]) begin
                found = 1'b1;
                win   = IDX_W'(j);
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (win == IDX_W'(j)) begin
                a_sel = bus.a_in[j*32 +: 32];
                b_sel = bus.b_in[j*32 +: 32];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        last_d   = last_q;
        wdog_d   = wdog_q;
        ack_d    = '0;
        done_d   = '0;
        err_d    = 1'b0;
        result_d = result_q;
        en_d     = 1'b0;
        a_d      = a_q;
        b_d      = b_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    a_d     = a_sel;
                    b_d     = b_sel;
                    g_d     = win;
                    last_d  = win;
                    ack_d   = {{(NREQ-1){1'b0}}, 1'b1} << win;
                    en_d    = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wdog_d = wdog_q + 1'b1;
                // A finish arriving on the timeout cycle still delivers its result.
                if (bus.atan_finish) begin
                    result_d = bus.atan_result;
                    done_d   = {{(NREQ-1){1'b0}}, 1'b1} << g_q;
                    state_d  = S_DONE;
                end else if (wdog_q == TMO_W'(TIMEOUT - 1)) begin
                    result_d = '0;
                    done_d   = {{(NREQ-1){1'b0}}, 1'b1} << g_q;
                    err_d    = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            g_q      <= '0;
            last_q   <= IDX_W'(NREQ - 1);
            wdog_q   <= '0;
            ack_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
            en_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            last_q   <= last_d;
            wdog_q   <= wdog_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
            en_q     <= en_d;
            a_q      <= a_d;
            b_q      <= b_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.ack     = ack_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.result  = result_q;
    assign bus.atan_en = en_q;
    assign bus.atan_a  = a_q;
    assign bus.atan_b  = b_q;
    assign bus.busy    = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ins_atan_arbiter.sv
// Bench for ins_atan_arbiter: INS_atan stub answers a^b after 40 cycles,
// expected done pulses are queued by the stimulus and checked by a monitor.
module tb_ins_atan_arbiter;
    localparam int NREQ    = 3;
    localparam int TIMEOUT = 200;
    localparam int W       = NREQ + 1 + 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] dbg_state;

    ins_atan_arbiter_if #(.NREQ(NREQ)) bus ();

    ins_atan_arbiter #(.NREQ(NREQ), .TMO_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];   // {done vector, err, result}
    int n_vec    = 0;
    int n_err    = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int en_cyc   = 0;
    bit stub_hang = 1'b0;

    task automatic check(input string nm, input logic [35:0] act, input logic [35:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- INS_atan stub ----------------
    initial begin
        int cnt;
        logic [31:0] sa, sb;
        cnt = 0;
        sa  = '0;
        sb  = '0;
        bus.atan_finish = 1'b0;
        bus.atan_result = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.atan_finish = 1'b0;
            if (!rst) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0 && !stub_hang) begin
                        bus.atan_finish = 1'b1;
                        bus.atan_result = sa ^ sb;
                    end
                end
                if (bus.atan_en) begin
                    sa  = bus.atan_a;
                    sb  = bus.atan_b;
                    cnt = 40;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst && bus.done != '0) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_busy", 36'(bus.busy), 36'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 36'(bus.done), 36'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_vec", 36'(bus.done), 36'(e[W-1 -: NREQ]));
                    check("done_err", 36'(bus.err), 36'(e[32]));
                    check("done_result", 36'(bus.result), 36'(e[31:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [NREQ-1:0] dv, input logic e, input logic [31:0] r);
        exp_q.push_back({dv, e, r});
    endtask

    task automatic wait_ack(input logic [NREQ-1:0] exp_vec, input string nm);
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (bus.ack != '0) break;
        end
        check(nm, 36'(bus.ack), 36'(exp_vec));
        check({nm, "_en"}, 36'(bus.atan_en), 36'd1);
        en_cyc = cyc;
    endtask

    task automatic wait_done(input int target, input string nm);
        for (int i = 0; i < 600; i++) begin
            tick(1);
            if (done_cnt >= target) break;
        end
        check(nm, 36'(done_cnt >= target), 36'd1);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_ctl"}, 36'({bus.ack, bus.done, bus.err, bus.busy, bus.atan_en}), 36'd0);
        check({nm, "_result"}, 36'(bus.result), 36'd0);
        check({nm, "_ab"}, 36'(bus.atan_a | bus.atan_b), 36'd0);
        check({nm, "_state"}, 36'(dbg_state), 36'd0);
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.a_in[i*32 +: 32] = a;
        bus.b_in[i*32 +: 32] = b;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        rst = 1'b0;
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b1;
        tick(2);

        // single request, exact latency
        set_ops(0, 32'h3F13CD3A, 32'h3F800000);
        push_exp(3'b001, 1'b0, 32'h0093CD3A);
        bus.req = 3'b001;
        tick(1);
        check("single_ack", 36'(bus.ack), 36'b001);
        check("single_en_hi", 36'(bus.atan_en), 36'd1);
        bus.req = '0;
        tick(1);
        check("single_en_lo", 36'(bus.atan_en), 36'd0);
        check("single_ack_lo", 36'(bus.ack), 36'd0);
        wait_done(1, "single_done");
        check("single_busy_after", 36'(bus.busy), 36'd0);

        // job on requester 2 so rotation restarts at 0
        set_ops(1, 32'h0000FFFF, 32'hFFFF0000);
        set_ops(2, 32'h12345678, 32'h12340000);
        push_exp(3'b100, 1'b0, 32'h00005678);
        bus.req = 3'b100;
        wait_ack(3'b100, "pre_ack2");
        bus.req = '0;
        wait_done(2, "pre_done2");

        // contention: all requesters held
        set_ops(0, 32'h11111111, 32'h22222222);
        push_exp(3'b001, 1'b0, 32'h33333333);
        push_exp(3'b010, 1'b0, 32'hFFFFFFFF);
        push_exp(3'b100, 1'b0, 32'h00005678);
        push_exp(3'b001, 1'b0, 32'h33333333);
        bus.req = 3'b111;
        wait_ack(3'b001, "cont_ack0");
        wait_ack(3'b010, "cont_ack1");
        wait_ack(3'b100, "cont_ack2");
        wait_ack(3'b001, "cont_ack0b");
        bus.req = '0;
        wait_done(6, "cont_done");

        // rotation after reset: last grant 2, reset, then req=110
        push_exp(3'b100, 1'b0, 32'h00005678);
        bus.req = 3'b100;
        wait_ack(3'b100, "rot_ack2");
        bus.req = '0;
        wait_done(7, "rot_done2");
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
        push_exp(3'b010, 1'b0, 32'hFFFFFFFF);
        push_exp(3'b100, 1'b0, 32'h00005678);
        bus.req = 3'b110;
        wait_ack(3'b010, "rot_ack1");
        wait_ack(3'b100, "rot_ack2b");
        bus.req = '0;
        wait_done(9, "rot_done");

        // watchdog: stub never finishes
        stub_hang = 1'b1;
        set_ops(0, 32'hDEADBEEF, 32'h01234567);
        push_exp(3'b001, 1'b1, 32'h00000000);
        bus.req = 3'b001;
        wait_ack(3'b001, "wdog_ack");
        bus.req = '0;
        wait_done(10, "wdog_done");
        check("wdog_latency", 36'(done_cyc - en_cyc), 36'(TIMEOUT + 1));
        stub_hang = 1'b0;
        push_exp(3'b010, 1'b0, 32'hFFFFFFFF);
        bus.req = 3'b010;
        wait_ack(3'b010, "post_wdog_ack");
        bus.req = '0;
        wait_done(11, "post_wdog_done");

        // operand stability after grant
        set_ops(0, 32'h40490FDB, 32'h3F800000);
        push_exp(3'b001, 1'b0, 32'h7FC90FDB);
        bus.req = 3'b001;
        wait_ack(3'b001, "stab_ack");
        bus.req = '0;
        tick(5);
        bus.a_in[31:0] = 32'hFFFFFFFF;
        tick(3);
        check("stab_atan_a", 36'(bus.atan_a), 36'h40490FDB);
        wait_done(12, "stab_done");

        // reset in the middle of WAIT: no done may follow
        set_ops(0, 32'hAAAA5555, 32'h00000000);
        bus.req = 3'b001;
        wait_ack(3'b001, "mid_ack");
        bus.req = '0;
        tick(10);
        rst = 1'b0;
        tick(1);
        check_reset_outputs("mid_reset");
        tick(1);
        rst = 1'b1;
        tick(50);
        check("mid_no_done", 36'(done_cnt), 36'd12);
        set_ops(0, 32'h0F0F0F0F, 32'h00FF00FF);
        push_exp(3'b001, 1'b0, 32'h0FF00FF0);
        bus.req = 3'b001;
        wait_ack(3'b001, "after_ack");
        bus.req = '0;
        wait_done(13, "after_done");

        tick(5);
        check("queue_empty", 36'(exp_q.size()), 36'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ins_atan_arbiter.md
Name: ins_atan_arbiter

Overview:
- Shares one INS_atan unit (float32 a,b in; float32 result out; en/atan_finish handshake) among NREQ requesters in the quadrotor INS, e.g. roll, pitch and yaw attitude stages.
- Arbitrates round-robin and latches the winner's operands.
- Pulses the unit's enable once and waits for atan_finish.
- Returns the result with a per-requester done pulse.
- Includes a watchdog so a hung conversion cannot lock out the other requesters.

Parameters:
- NREQ, 3, number of requesters (2..8).
- TMO_W, 8, width of the watchdog counter.
- TIMEOUT, 200, cycles in WAIT before abort (must be < 2^TMO_W).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request level
- a_in  in  NREQ*32  operand a; requester i uses bits [32i+31:32i]
- b_in  in  NREQ*32  operand b; same packing as a_in
- ack  out  NREQ  one-cycle pulse: operands of requester i have been latched
- done  out  NREQ  one-cycle pulse: result valid for requester i
- result  out  32  float32 result, valid while done is nonzero; held until the next done
- err  out  1  high together with done when that job was aborted by the watchdog
- busy  out  1  high in every state except IDLE
- atan_en  out  1  to INS_atan en
- atan_a  out  32  to INS_atan a
- atan_b  out  32  to INS_atan b
- atan_result  in  32  from INS_atan result
- atan_finish  in  1  from INS_atan atan_finish

Behaviour:
- All outputs are registered.
- Reset values:
  - ack, done, err, busy, atan_en = 0.
  - result, atan_a, atan_b = 0.
  - State = IDLE; watchdog = 0.
  - last_grant = NREQ-1, so requester 0 has first priority.
  - Asserting reset mid-operation aborts the job with no done pulse; the shared INS_atan is reset by the same rst.
- IDLE:
  - If req is nonzero, pick the first set bit searching upward (modulo NREQ) from last_grant+1.
  - On that edge: latch the winner's operands into atan_a/atan_b, set g = winner and last_grant = winner, pulse ack[g], set atan_en = 1, go to ISSUE.
  - atan_finish seen in IDLE is ignored.
- ISSUE (1 cycle):
  - atan_en is high during this cycle only and is cleared on exit.
  - Clear the watchdog; go to WAIT.
- WAIT:
  - atan_a/atan_b are held stable, because INS_atan re-samples a/b while it sits in its own IDLE.
  - Watchdog increments every cycle.
  - If atan_finish = 1: result <= atan_result, done[g] <= 1, err <= 0, go to DONE.
  - Else if watchdog == TIMEOUT-1: result <= 0, done[g] <= 1, err <= 1, go to DONE.
  - If finish and timeout occur in the same cycle, finish wins.
- DONE (1 cycle):
  - done and err are high during this cycle only.
  - Go to IDLE. A new grant can be issued on the cycle after DONE; there is no back-to-back overlap.
- Latency:
  - req sampled at edge E: ack and atan_en are high in cycle E+1.
  - atan_finish seen at edge F: done is high in cycle F+1.
  - Arbitration overhead is 3 cycles per job beyond INS_atan latency.
- Requester rules:
  - req is a level. The requester must drop req in the cycle ack is seen. A req still high after DONE is treated as a new request.
  - Operands are sampled only at the grant edge; later operand changes are ignored.
- Fairness: with all req held continuously, grants rotate 0,1,2,0,… and each requester waits at most NREQ-1 jobs.
- Stray atan_finish in ISSUE is ignored.

Test Plan:
- Stub INS_atan answers result = a XOR b after 40 cycles, with a 1-cycle finish pulse.
- Single request: req=001, a0=3F13CD3A, b0=3F800000 -> ack=001 one cycle after req; atan_en exactly 1 cycle; done=001 with result=0093CD3A, err=0; busy back to 0 the cycle after DONE.
- Contention: req=111 held throughout, distinct operands per requester -> grant order 0,1,2,0; each done[i] carries its own a_i^b_i; no two jobs overlap.
- Rotation after reset: last grant was 2, then reset, then req=110 -> requester 1 granted first; then 2.
- Watchdog: stub never asserts finish -> done[g]=1, err=1, result=0 exactly TIMEOUT+1 cycles after the atan_en cycle; the next request is serviced normally.
- Operand stability: change a_in 5 cycles after ack -> atan_a unchanged until DONE; result uses the latched value.
- Reset mid-WAIT: rst low 2 cycles -> all outputs 0, no done; after release, req=001 -> a normal job completes.
